// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop,
// LSB first, WIDTH cycles per operation behind a start/busy/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb, sd;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             d, brw_nxt, last;

   always_comb begin
      d       = sa[0] ^ sb[0] ^ brw;
      brw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= IDLE;
      else if (ena) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // diff/bout are loaded only on the last bit, so they never expose partial results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa   <= '0;
         sb   <= '0;
         sd   <= '0;
         brw  <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  brw <= bin;
                  cnt <= '0;
               end
            end
            RUN: begin
               sa  <= {1'b0, sa[WIDTH-1:1]};
               sb  <= {1'b0, sb[WIDTH-1:1]};
               sd  <= {d, sd[WIDTH-1:1]};
               brw <= brw_nxt;
               cnt <= cnt + CW'(1);
               if (last) begin
                  diff <= {d, sd[WIDTH-1:1]};
                  bout <= brw_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): table of operand/result
// vectors plus hand sequences for ignored start, ena gaps and mid-run reset.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       bin = 1'b0;
   logic [3:0] diff;
   logic       bout, busy, done;

   int n_chk = 0;
   int n_pass = 0;

   serial_subtractor #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .a(a), .b(b), .bin(bin),
      .diff(diff), .bout(bout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] va;
      logic [3:0] vb;
      logic       vbin;
      logic [3:0] ediff;
      logic       ebout;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Issues one start pulse and counts rising edges from the accepting edge
   // until done is seen (bounded); busy_n counts sampled busy cycles.
   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic tbin, input int gap_at, input int gap_len,
                         output int lat, output int busy_n);
      @(negedge clk);
      a = ta; b = tb_v; bin = tbin; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busy_n = 0;
      while (!done && lat < 50) begin
         if (busy) busy_n++;
         if (lat == gap_at) begin
            ena = 1'b0;
            repeat (gap_len) begin
               @(posedge clk); lat++; @(negedge clk);
               chk("gap_done_low", int'(done), 0);
               chk("gap_busy_high", int'(busy), 1);
            end
            ena = 1'b1;
         end
         @(posedge clk); lat++; @(negedge clk);
      end
      if (busy) busy_n++;
   endtask

   initial begin
      int lat, busy_n, pulses;

      vecs[0] = '{4'd9, 4'd3,  1'b0, 4'd6,  1'b0};
      vecs[1] = '{4'd3, 4'd9,  1'b0, 4'd10, 1'b1};
      vecs[2] = '{4'd0, 4'd1,  1'b0, 4'd15, 1'b1};
      vecs[3] = '{4'd0, 4'd0,  1'b0, 4'd0,  1'b0};
      vecs[4] = '{4'd5, 4'd2,  1'b1, 4'd2,  1'b0};
      vecs[5] = '{4'd0, 4'd15, 1'b1, 4'd0,  1'b1};

      repeat (3) @(negedge clk);
      chk("rst_diff", int'(diff), 0);
      chk("rst_bout", int'(bout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, -1, 0, lat, busy_n);
         chk($sformatf("v%0d_latency", i), lat, 4);
         chk($sformatf("v%0d_diff", i), int'(diff), int'(vecs[i].ediff));
         chk($sformatf("v%0d_bout", i), int'(bout), int'(vecs[i].ebout));
         if (i == 0) chk("v0_busy_cycles", busy_n, 5);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse_end", i), int'(done), 0);
         chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      end

      // Second start during RUN with changed operands must be ignored.
      a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      pulses = 0;
      @(posedge clk); @(negedge clk);
      a = 4'd1; b = 4'd1; start = 1'b1;
      chk("hold_bout_mid_run", int'(bout), 1);
      chk("hold_diff_mid_run", int'(diff), 0);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (8) begin
         if (done) pulses++;
         @(posedge clk); @(negedge clk);
      end
      chk("ignored_start_pulses", pulses, 1);
      chk("ignored_start_diff", int'(diff), 6);
      chk("ignored_start_bout", int'(bout), 0);
      chk("ignored_start_idle", int'(busy), 0);

      // ena low for 3 cycles mid-RUN stretches latency by 3.
      run_op(4'd12, 4'd4, 1'b0, 2, 3, lat, busy_n);
      chk("gap_latency", lat, 7);
      chk("gap_diff", int'(diff), 8);
      chk("gap_bout", int'(bout), 0);

      // Asynchronous reset after two RUN edges aborts with no done pulse.
      @(negedge clk);
      a = 4'd7; b = 4'd1; bin = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk("pre_reset_busy", int'(busy), 1);
      chk("pre_reset_diff", int'(diff), 8);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_diff", int'(diff), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_bout", int'(bout), 0);
      pulses = 0;
      repeat (4) begin
         @(posedge clk); @(negedge clk);
         if (done) pulses++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         if (done) pulses++;
      end
      chk("reset_no_done", pulses, 0);
      run_op(4'd7, 4'd1, 1'b0, -1, 0, lat, busy_n);
      chk("post_reset_latency", lat, 4);
      chk("post_reset_diff", int'(diff), 6);
      chk("post_reset_bout", int'(bout), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
